// File: rtl/ysyx_23060136_exu_ctrl.sv
// ysyx_23060136_exu_ctrl -- execute-stage handshake controller.
//
// Drives the combinational ALU straight from the decode stage, captures the
// ALU result into an output register one cycle after acceptance and holds it
// until the LSU takes it. Ops that are not exactly one-hot are still accepted
// but yield a zero result, are flagged illegal and are counted (saturating).
//
// Build option: define YSYX_23060136_EXU_SKID_EN to add a one-entry skid
// buffer. EXU_ready then depends only on registered state. Without it,
// EXU_ready = !EXU_valid | LSU_ready.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   IDU_valid / EXU_ready          upstream handshake
//   IDU_op, IDU_da, IDU_db         one-hot op and operands from decode
//   EXU_ALU_op/_da/_db             mirrored to the ALU
//   EXU_ALU_ALUout                 combinational ALU result
//   EXU_flush                      discard held and incoming work
//   EXU_valid / LSU_ready          downstream handshake
//   EXU_result, EXU_illegal        held result and its illegal flag
//   EXU_illegal_cnt                saturating count of accepted illegal ops
module ysyx_23060136_exu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        IDU_valid,
   output logic        EXU_ready,
   input  logic [10:0] IDU_op,
   input  logic [31:0] IDU_da,
   input  logic [31:0] IDU_db,
   output logic [10:0] EXU_ALU_op,
   output logic [31:0] EXU_ALU_da,
   output logic [31:0] EXU_ALU_db,
   input  logic [31:0] EXU_ALU_ALUout,
   input  logic        EXU_flush,
   output logic        EXU_valid,
   input  logic        LSU_ready,
   output logic [31:0] EXU_result,
   output logic        EXU_illegal,
   output logic [7:0]  EXU_illegal_cnt
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e      state_q;
   logic [31:0] result_q;
   logic        illegal_q;
   logic [7:0]  cnt_q;
`ifdef YSYX_23060136_EXU_SKID_EN
   logic [31:0] skid_result_q;
   logic        skid_illegal_q;
`endif

   logic        op_legal;
   logic [31:0] new_result;
   logic        accept;
   logic        deliver;

   assign EXU_ALU_op = IDU_op;
   assign EXU_ALU_da = IDU_da;
   assign EXU_ALU_db = IDU_db;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign op_legal   = (IDU_op != 11'd0) && ((IDU_op & (IDU_op - 11'd1)) == 11'd0);
   assign new_result = op_legal ? EXU_ALU_ALUout : 32'd0;

`ifdef YSYX_23060136_EXU_SKID_EN
   assign EXU_ready = (state_q != StTwo);
`else
   assign EXU_ready = (state_q == StEmpty) | LSU_ready;
`endif

   assign EXU_valid       = (state_q != StEmpty);
   assign accept          = IDU_valid & EXU_ready & ~EXU_flush;
   assign deliver         = EXU_valid & LSU_ready;
   assign EXU_result      = result_q;
   assign EXU_illegal     = illegal_q;
   assign EXU_illegal_cnt = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StEmpty;
         result_q       <= 32'd0;
         illegal_q      <= 1'b0;
         cnt_q          <= 8'd0;
`ifdef YSYX_23060136_EXU_SKID_EN
         skid_result_q  <= 32'd0;
         skid_illegal_q <= 1'b0;
`endif
      end else begin
         if (accept && !op_legal && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
         end

         if (EXU_flush) begin
            state_q <= StEmpty;
         end else begin
            unique case (state_q)
               StEmpty: begin
                  if (accept) begin
                     result_q  <= new_result;
                     illegal_q <= ~op_legal;
                     state_q   <= StOne;
                  end
               end
               StOne: begin
                  if (accept && deliver) begin
                     result_q  <= new_result;
                     illegal_q <= ~op_legal;
                  end else if (deliver) begin
                     state_q <= StEmpty;
`ifdef YSYX_23060136_EXU_SKID_EN
                  end else if (accept) begin
                     // Output register is stalled; park the new entry.
                     skid_result_q  <= new_result;
                     skid_illegal_q <= ~op_legal;
                     state_q        <= StTwo;
`endif
                  end
               end
`ifdef YSYX_23060136_EXU_SKID_EN
               StTwo: begin
                  if (deliver) begin
                     result_q  <= skid_result_q;
                     illegal_q <= skid_illegal_q;
                     state_q   <= StOne;
                  end
               end
`endif
               default: state_q <= StEmpty;
            endcase
         end
      end
   end

endmodule
